bcd_time_counter: RTL
=====================

BCD_TIME_COUNTER -- requirements
Module: bcd_time_counter

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50_000_000, meaning clk cycles per one-second tick (legal range >= 2).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port run_en, input, 1, level; when 0 the prescaler holds its value, so time freezes.
REQ-005 SHALL have port key_mode, input, 1, single-cycle debounced pulse that advances the mode.
REQ-006 SHALL have port key_inc, input, 1, single-cycle debounced pulse that increments the selected field.
REQ-007 SHALL have port bcd_data, output, 24, registered time as {H10,H1,M10,M1,S10,S1}, 4-bit BCD each; [23:20]=H10, [3:0]=S1; feeds the 6-digit display driver directly.
REQ-008 SHALL have port mode, output, 2, registered mode code: 0=RUN, 1=SET_H, 2=SET_M, 3=SET_S.
REQ-009 SHALL have port day_pulse, output, 1, registered; high for exactly one cycle on rollover from 23:59:59 to 00:00:00.

Function
REQ-010 SHALL implement a 4-state FSM RUN->SET_H->SET_M->SET_S->RUN, advancing one state per key_mode pulse; no other transitions.
REQ-011 The prescaler SHALL count 0..CLK_DIV-1 in RUN when run_en=1; at CLK_DIV-1 it SHALL wrap to 0 and generate an internal tick.
REQ-012 On a tick, S1 SHALL increment; 9->0 carries to S10; S10 5->0 carries to M1; M1 9->0 carries to M10; M10 5->0 carries to H1; H1 increments 9->0 with carry to H10; 23 SHALL wrap to 00.
REQ-013 bcd_data SHALL reflect a tick on the clock edge following the cycle in which the prescaler equals CLK_DIV-1, i.e. one update every CLK_DIV cycles.
REQ-014 day_pulse SHALL assert in the same cycle that bcd_data becomes 24'h000000 due to rollover, and deassert the next cycle.
REQ-015 In SET_H/SET_M/SET_S the prescaler SHALL be held at 0 and no ticks SHALL occur.
REQ-016 key_inc in SET_H SHALL increment hours 00..23 with wrap 23->00; in SET_M SHALL increment minutes 00..59 with wrap 59->00; in SET_S SHALL increment seconds 00..59 with wrap 59->00; no carry into neighbouring fields; day_pulse SHALL stay 0.
REQ-017 key_inc in RUN SHALL be ignored.
REQ-018 Transition SET_S->RUN SHALL restart the prescaler from 0, so the first tick occurs CLK_DIV cycles after re-entering RUN.
REQ-019 If key_mode and a tick coincide in RUN, the mode change SHALL win and the tick SHALL be discarded.
REQ-020 If key_mode and key_inc coincide in a SET state, the mode SHALL advance and the increment SHALL be discarded.
REQ-021 run_en=0 SHALL not affect SET-state editing or FSM transitions.
REQ-022 Every digit of bcd_data SHALL hold a legal BCD value at all times; H10<=2, H10=2 implies H1<=3, S10<=5, M10<=5.

Reset
REQ-023 While rst_=0, SHALL force bcd_data=24'h000000, mode=0 (RUN), day_pulse=0, prescaler=0, asynchronously.
REQ-024 Reset asserted mid-operation (any state, mid-count, mid-edit) SHALL discard all progress; after release, the first tick SHALL occur CLK_DIV cycles after the first clk edge with rst_=1 and run_en=1.

Verification (CLK_DIV=4)
REQ-025 Reset release, run_en=1 for 40 cycles -> bcd_data=24'h000010 (10 seconds), day_pulse never high.
REQ-026 Set 23:59:58 via SET states, return to RUN, run 8 cycles -> 23:59:59 then 24'h000000 with day_pulse high exactly one cycle.
REQ-027 In SET_M at minutes 59, one key_inc -> minutes 00, hours unchanged; in SET_H at 23, one key_inc -> 00.
REQ-028 run_en=0 for 100 cycles in RUN -> bcd_data unchanged; re-enable -> counting resumes from the held prescaler value.
REQ-029 key_mode on the tick cycle in RUN -> mode=1, seconds not incremented; key_mode+key_inc together in SET_H -> mode=2, hours unchanged.
REQ-030 rst_ pulsed low mid-edit in SET_M at 12:34:56 -> immediately 24'h000000, mode=0; normal counting afterward.

Source files
------------

// File: rtl/bcd_time_counter.sv
// 24-hour BCD time-of-day counter with a run mode and three field-edit modes.
// A prescaler divides clk down to a one-second tick that ripples through hh:mm:ss.
module bcd_time_counter #(
    parameter int CLK_DIV = 50_000_000
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic        run_en,
    input  logic        key_mode,
    input  logic        key_inc,
    output logic [23:0] bcd_data,
    output logic [1:0]  mode,
    output logic        day_pulse
);

    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SET_H = 2'd1,
        ST_SET_M = 2'd2,
        ST_SET_S = 2'd3
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_presc;
    logic [7:0]    r_hh;
    logic [7:0]    r_mm;
    logic [7:0]    r_ss;
    logic          r_day;

    logic w_tick;
    logic w_sec_wrap;
    logic w_min_wrap;
    logic w_day_wrap;

    // Two-digit BCD increment that wraps to 00 after reaching lim.
    function automatic logic [7:0] f_bcd_inc(input logic [7:0] v, input logic [7:0] lim);
        if (v == lim)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign w_tick     = (r_state == ST_RUN) && run_en && (r_presc == PRESC_LAST);
    assign w_sec_wrap = (r_ss == 8'h59);
    assign w_min_wrap = (r_mm == 8'h59);
    assign w_day_wrap = w_sec_wrap && w_min_wrap && (r_hh == 8'h23);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state <= ST_RUN;
            r_presc <= '0;
            r_hh    <= 8'h00;
            r_mm    <= 8'h00;
            r_ss    <= 8'h00;
            r_day   <= 1'b0;
        end else begin
            r_day <= 1'b0;
            // A mode key pre-empts both a pending tick and a simultaneous increment.
            if (key_mode) begin
                r_state <= state_t'(r_state + 2'd1);
                r_presc <= '0;
            end else begin
                case (r_state)
                    ST_RUN: begin
                        if (w_tick) begin
                            r_presc <= '0;
                            r_ss    <= f_bcd_inc(r_ss, 8'h59);
                            if (w_sec_wrap)
                                r_mm <= f_bcd_inc(r_mm, 8'h59);
                            if (w_sec_wrap && w_min_wrap)
                                r_hh <= f_bcd_inc(r_hh, 8'h23);
                            r_day <= w_day_wrap;
                        end else if (run_en) begin
                            r_presc <= r_presc + PW'(1);
                        end
                    end
                    ST_SET_H: begin
                        r_presc <= '0;
                        if (key_inc)
                            r_hh <= f_bcd_inc(r_hh, 8'h23);
                    end
                    ST_SET_M: begin
                        r_presc <= '0;
                        if (key_inc)
                            r_mm <= f_bcd_inc(r_mm, 8'h59);
                    end
                    ST_SET_S: begin
                        r_presc <= '0;
                        if (key_inc)
                            r_ss <= f_bcd_inc(r_ss, 8'h59);
                    end
                    default: r_state <= ST_RUN;
                endcase
            end
        end
    end

    assign bcd_data  = {r_hh, r_mm, r_ss};
    assign mode      = r_state;
    assign day_pulse = r_day;

endmodule
